// File: rtl/fsm_scheduler.sv
// Round-robin scheduler that time-shares one external bit-serial FSM among four
// requesters: each job clears the FSM, streams a word MSB first and captures the reply.
module fsm_scheduler #(
    parameter int N_BITS = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [3:0]            req,
    input  logic [4*N_BITS-1:0]   req_data,
    output logic [3:0]            grant,
    output logic                  busy,
    output logic                  fsm_reset_b,
    output logic                  fsm_in,
    input  logic                  fsm_out,
    output logic                  done,
    output logic [1:0]            done_id,
    output logic [N_BITS-1:0]     result
);

    localparam int               CNT_W = $clog2(N_BITS);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(N_BITS - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, DONE} state_t;

    state_t              state_q, state_d;
    logic [1:0]          win_q, win_d;
    logic [1:0]          ptr_q;
    logic [1:0]          pick;
    logic [CNT_W-1:0]    cnt_q;
    logic [N_BITS-1:0]   word_q;

    // First requester at or after p, wrapping mod 4; the loop runs backwards so the
    // smallest offset from p wins.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        rr_pick = p;
        for (int i = 3; i >= 0; i--) begin
            idx = p + 2'(i);
            if (r[idx]) rr_pick = idx;
        end
    endfunction

    always_comb begin
        pick    = rr_pick(req, ptr_q);
        state_d = state_q;
        win_d   = win_q;
        case (state_q)
            IDLE, DONE: begin
                if (|req) begin
                    state_d = CLEAR;
                    win_d   = pick;
                end else begin
                    state_d = IDLE;
                end
            end
            CLEAR:   state_d = req[win_q] ? SHIFT : IDLE;
            SHIFT: begin
                if (!req[win_q])        state_d = IDLE;
                else if (cnt_q == LAST) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            win_q   <= 2'd0;
            ptr_q   <= 2'd0;
            cnt_q   <= '0;
            result  <= '0;
            done_id <= 2'd0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            if (state_d == CLEAR) ptr_q <= win_d + 2'd1;
            if (state_q == CLEAR)      cnt_q <= '0;
            else if (state_q == SHIFT) cnt_q <= cnt_q + CNT_W'(1);
            // An abort on the final shift cycle goes to IDLE, so this never fires for it.
            if (state_d == DONE) begin
                result  <= {word_q[N_BITS-2:0], fsm_out};
                done_id <= win_q;
            end
        end
    end

    // One register serves as both transmit and receive shifter: the MSB leaves on
    // fsm_in while the FSM reply enters at the LSB, so after N_BITS shifts it holds the reply.
    always_ff @(posedge clock) begin
        if (state_d == CLEAR)      word_q <= req_data[win_d*N_BITS +: N_BITS];
        else if (state_q == SHIFT) word_q <= {word_q[N_BITS-2:0], fsm_out};
    end

    assign busy        = (state_q != IDLE);
    assign grant       = busy ? (4'b0001 << win_q) : 4'b0000;
    assign done        = (state_q == DONE);
    assign fsm_reset_b = !reset && (state_q != CLEAR);
    assign fsm_in      = (state_q == SHIFT) && word_q[N_BITS-1];

endmodule

// File: tb/tb_fsm_scheduler.sv
// Bench for fsm_scheduler: a small shared serial FSM is attached, and jobs are
// checked against a transaction-level model (round-robin pointer plus closed-form reply).
module tb_fsm_scheduler;

    localparam int N = 8;

    logic             clock = 1'b0;
    logic             reset;
    logic [3:0]       req;
    logic [4*N-1:0]   req_data;
    logic [3:0]       grant;
    logic             busy, fsm_reset_b, fsm_in, fsm_out, done;
    logic [1:0]       done_id;
    logic [N-1:0]     result;

    int               n_checks = 0;
    int               n_pass   = 0;
    int               ptr_m;
    logic [N-1:0]     last_result;
    logic [1:0]       last_id;
    logic             env_s2;

    fsm_scheduler #(.N_BITS(N)) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .req_data    (req_data),
        .grant       (grant),
        .busy        (busy),
        .fsm_reset_b (fsm_reset_b),
        .fsm_in      (fsm_in),
        .fsm_out     (fsm_out),
        .done        (done),
        .done_id     (done_id),
        .result      (result)
    );

    always #5 clock = ~clock;

    // Shared FSM: S0 --0/1--> S0, S0 --1/0--> S2, S2 --1/1--> S2, S2 --0/0--> S0
    always @(posedge clock) begin
        if (!fsm_reset_b) env_s2 <= 1'b0;
        else              env_s2 <= fsm_in;
    end
    assign fsm_out = env_s2 ? fsm_in : ~fsm_in;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Reply bit k is 1 exactly when input bit k equals the previous input bit (start bit = 0).
    function automatic logic [N-1:0] expect_reply(input logic [N-1:0] w);
        return ~(w ^ (w >> 1));
    endfunction

    function automatic int rr_model(input logic [3:0] r, input int p);
        for (int i = 0; i < 4; i++) begin
            if (r[(p + i) % 4]) return (p + i) % 4;
        end
        return 0;
    endfunction

    task automatic check_idle();
        check("idle_busy",    32'(busy),        32'd0);
        check("idle_grant",   32'(grant),       32'd0);
        check("idle_done",    32'(done),        32'd0);
        check("idle_rstb",    32'(fsm_reset_b), 32'd1);
        check("idle_fsm_in",  32'(fsm_in),      32'd0);
        check("idle_result",  32'(result),      32'(last_result));
        check("idle_done_id", 32'(done_id),     32'(last_id));
    endtask

    task automatic check_reset_vals();
        check("rst_grant",   32'(grant),       32'd0);
        check("rst_busy",    32'(busy),        32'd0);
        check("rst_done",    32'(done),        32'd0);
        check("rst_result",  32'(result),      32'd0);
        check("rst_done_id", 32'(done_id),     32'd0);
        check("rst_rstb",    32'(fsm_reset_b), 32'd0);
        check("rst_fsm_in",  32'(fsm_in),      32'd0);
    endtask

    // Entered at a negedge of an IDLE or DONE cycle; returns at the negedge of the
    // final DONE cycle, or of the IDLE cycle following an abort or reset.
    task automatic run_job(input logic [3:0] r, input logic [4*N-1:0] d,
                           input int abort_k, input int reset_k);
        int           win;
        logic [N-1:0] w;
        logic [N-1:0] expr;
        win  = rr_model(r, ptr_m);
        req      = r;
        req_data = d;
        w    = d[win*N +: N];
        expr = expect_reply(w);

        @(negedge clock);
        check("clr_grant",  32'(grant),       32'(4'b0001 << win));
        check("clr_busy",   32'(busy),        32'd1);
        check("clr_rstb",   32'(fsm_reset_b), 32'd0);
        check("clr_fsm_in", 32'(fsm_in),      32'd0);
        check("clr_done",   32'(done),        32'd0);
        ptr_m    = (win + 1) % 4;
        req_data = $urandom;

        for (int k = 0; k < N; k++) begin
            @(negedge clock);
            check("sh_grant",  32'(grant),       32'(4'b0001 << win));
            check("sh_fsm_in", 32'(fsm_in),      32'(w[N-1-k]));
            check("sh_rstb",   32'(fsm_reset_b), 32'd1);
            check("sh_done",   32'(done),        32'd0);
            if (k == abort_k) begin
                req[win] = 1'b0;
                @(negedge clock);
                check_idle();
                return;
            end
            if (k == reset_k) begin
                reset = 1'b1;
                #1;
                check_reset_vals();
                @(negedge clock);
                check_reset_vals();
                reset       = 1'b0;
                ptr_m       = 0;
                last_result = '0;
                last_id     = 2'd0;
                return;
            end
            req_data = $urandom;
        end

        @(negedge clock);
        check("dn_done",    32'(done),        32'd1);
        check("dn_done_id", 32'(done_id),     32'(win));
        check("dn_result",  32'(result),      32'(expr));
        check("dn_grant",   32'(grant),       32'(4'b0001 << win));
        check("dn_busy",    32'(busy),        32'd1);
        check("dn_rstb",    32'(fsm_reset_b), 32'd1);
        check("dn_fsm_in",  32'(fsm_in),      32'd0);
        last_result = expr;
        last_id     = 2'(win);
    endtask

    initial begin
        logic [4*N-1:0] d;
        int             ab;
        int             gaps;
        logic [3:0]     r;

        reset    = 1'b1;
        req      = 4'b1111;
        req_data = $urandom;
        repeat (2) @(negedge clock);
        check_reset_vals();

        reset       = 1'b0;
        req         = 4'b0000;
        ptr_m       = 0;
        last_result = '0;
        last_id     = 2'd0;
        @(negedge clock);
        check_idle();

        d = $urandom; d[7:0] = 8'hFF;
        run_job(4'b0001, d, -1, -1);
        check("word_ff", 32'(result), 32'h7F);
        d = $urandom; d[7:0] = 8'h00;
        run_job(4'b0001, d, -1, -1);
        check("word_00", 32'(result), 32'hFF);
        d = $urandom; d[7:0] = 8'h80;
        run_job(4'b0001, d, -1, -1);
        check("word_80", 32'(result), 32'h3F);

        // Serve requester 3 so the pointer wraps to 0, then a back-to-back round.
        run_job(4'b1000, $urandom, -1, -1);
        repeat (5) run_job(4'b1111, $urandom, -1, -1);
        req = 4'b0000;
        @(negedge clock);
        check_idle();

        run_job(4'b0100, $urandom, 3, -1);
        run_job(4'b1000, $urandom, -1, -1);

        run_job(4'b0110, $urandom, -1, 5);
        run_job(4'b1111, $urandom, -1, -1);

        for (int j = 0; j < 40; j++) begin
            gaps = $urandom_range(0, 2);
            repeat (gaps) begin
                req = 4'b0000;
                @(negedge clock);
                check_idle();
            end
            r  = 4'($urandom_range(1, 15));
            ab = ($urandom_range(0, 7) == 0) ? $urandom_range(0, N - 1) : -1;
            run_job(r, $urandom, ab, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
